// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_ctrl
// Brief   : Instruction fetch sequencer with valid/ready output, redirect,
//           end-of-memory halt and sticky bad-target error.
// Revision: 1.0
// ============================================================================
module inst_fetch_ctrl #(
    parameter int          MEM_BYTES = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        done,
    output logic        err,
    output logic [31:0] instr_count
);

    localparam logic [31:0] c_LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_instr_count;

    logic w_redirect;
    logic w_target_ok;
    logic w_capture;
    logic w_accept;
    logic w_last;

    // ERR ignores redirects entirely; only reset leaves it.
    assign w_redirect  = redirect_valid && (r_state != ST_ERR);
    assign w_target_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= c_LAST_PC);
    assign w_accept    = r_out_valid && out_ready;
    assign w_last      = (r_pc == c_LAST_PC);
    assign w_capture   = (r_state == ST_FETCH) && fetch_en && !redirect_valid
                         && (!r_out_valid || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) begin
            if (!w_target_ok) begin
                w_state_nxt = ST_ERR;
            end else if (fetch_en) begin
                w_state_nxt = ST_FETCH;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fetch_en) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!fetch_en) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_capture && w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_out_valid   <= 1'b0;
            r_out_instr   <= 32'h0;
            r_out_pc      <= 32'h0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_instr_count <= 32'h0;
        end else begin
            if (w_redirect) begin
                r_out_valid <= 1'b0;
                if (w_target_ok) begin
                    r_pc   <= redirect_pc;
                    r_done <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (w_capture) begin
                r_out_instr <= imem_instr;
                r_out_pc    <= r_pc;
                r_out_valid <= 1'b1;
                r_pc        <= r_pc + 32'd4;
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            // A flushed word still counts if decode took it this cycle.
            if (w_accept) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    assign imem_pc     = r_pc;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign done        = r_done;
    assign err         = r_err;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch_ctrl
// Brief   : Directed plus randomized bench for inst_fetch_ctrl against a
//           behavioural reference model.
// Revision: 1.0
// ============================================================================
module tb_inst_fetch_ctrl;

    localparam int c_MEM_BYTES = 32;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        done;
    logic        err;
    logic [31:0] instr_count;

    logic [31:0] mem [8];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 running, 2 halted at end, 3 error
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    logic        m_done;
    logic        m_err;
    logic [31:0] m_cnt;

    inst_fetch_ctrl #(.MEM_BYTES(c_MEM_BYTES), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .done           (done),
        .err            (err),
        .instr_count    (instr_count)
    );

    assign imem_instr = (imem_pc < 32'(c_MEM_BYTES)) ? mem[imem_pc[4:2]] : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_opc   = 32'h0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 32'h0;
    endtask

    // One clock edge of the specified behaviour, using the inputs held before the edge.
    task automatic model_step();
        logic acc;
        logic took;
        acc  = m_valid && out_ready;
        took = 1'b0;
        if (m_mode != 3 && redirect_valid) begin
            m_valid = 1'b0;
            if (redirect_pc % 4 == 0 && redirect_pc <= 32'(c_MEM_BYTES - 4)) begin
                m_pc   = redirect_pc;
                m_done = 1'b0;
                m_mode = fetch_en ? 1 : 0;
            end else begin
                m_err  = 1'b1;
                m_mode = 3;
            end
        end else if (m_mode == 0) begin
            if (fetch_en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!fetch_en) begin
                m_mode = 0;
            end else if (!m_valid || out_ready) begin
                took    = 1'b1;
                m_instr = mem[m_pc / 4];
                m_opc   = m_pc;
                m_valid = 1'b1;
                if (m_pc == 32'(c_MEM_BYTES - 4)) begin
                    m_done = 1'b1;
                    m_mode = 2;
                end
                m_pc = m_pc + 4;
            end
        end
        if (!redirect_valid || m_mode == 3) begin
            if (acc && !took) m_valid = 1'b0;
        end
        if (acc) m_cnt = m_cnt + 1;
    endtask

    task automatic check_all();
        chk("out_valid",   {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_instr",   out_instr, m_instr);
        chk("out_pc",      out_pc, m_opc);
        chk("imem_pc",     imem_pc, m_pc);
        chk("done",        {31'b0, done}, {31'b0, m_done});
        chk("err",         {31'b0, err}, {31'b0, m_err});
        chk("instr_count", instr_count, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        mem[0] = 32'h00940333; mem[1] = 32'h413903b3; mem[2] = 32'h035a02b3; mem[3] = 32'h01de8e33;
        mem[4] = 32'h019c1eb3; mem[5] = 32'h40b50533; mem[6] = 32'h00c5f633; mem[7] = 32'h00f768b3;
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        // Straight run through memory with decode always ready
        fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        chk("t1_no_valid_yet", {31'b0, out_valid}, 32'd0);
        tick();
        chk("t1_first_instr", out_instr, 32'h00940333);
        tick();
        chk("t1_second_pc", out_pc, 32'd4);
        repeat (7) tick();
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_count", instr_count, 32'd8);

        // Backpressure while pc 4 is presented
        async_reset();
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("t2_hold_instr", out_instr, 32'h413903b3);
            chk("t2_hold_imem", imem_pc, 32'd8);
        end
        out_ready = 1'b1;
        tick();
        chk("t2_release_pc", out_pc, 32'd8);
        chk("t2_release_instr", out_instr, 32'h035a02b3);

        // Redirect to 0x10 while pc 8 is presented
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        chk("t3_flush", {31'b0, out_valid}, 32'd0);
        chk("t3_imem", imem_pc, 32'h10);
        tick();
        chk("t3_instr", out_instr, 32'h019c1eb3);
        chk("t3_pc", out_pc, 32'h10);

        // Misaligned and out-of-range targets are terminal errors
        for (int k = 0; k < 2; k++) begin
            logic [31:0] frozen;
            async_reset();
            repeat (3) tick();
            frozen = imem_pc;
            redirect_valid = 1'b1; redirect_pc = (k == 0) ? 32'h06 : 32'h20;
            tick();
            chk("t4_err", {31'b0, err}, 32'd1);
            chk("t4_imem_frozen", imem_pc, frozen);
            redirect_pc = 32'h0;
            repeat (3) tick();
            redirect_valid = 1'b0;
            chk("t4_still_err", {31'b0, err}, 32'd1);
            chk("t4_still_frozen", imem_pc, frozen);
        end

        // Halt at end, drain, then redirect to 0 restarts fetching
        async_reset();
        repeat (12) tick();
        chk("t6_done", {31'b0, done}, 32'd1);
        chk("t6_drained", {31'b0, out_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("t6_done_clr", {31'b0, done}, 32'd0);
        tick();
        chk("t6_restart", out_instr, 32'h00940333);

        // Randomized traffic, with mid-cycle resets
        async_reset();
        for (int i = 0; i < 3000; i++) begin
            fetch_en       = ($urandom_range(0, 7) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 15))
                0:       redirect_pc = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
                1:       redirect_pc = 32'($urandom_range(8, 64) * 4);
                default: redirect_pc = 32'($urandom_range(0, 7) * 4);
            endcase
            if ($urandom_range(0, 79) == 0) begin
                redirect_valid = 1'b0;
                async_reset();
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
